ssd_capture: RTL and testbench

SSD_CAPTURE -- requirements
Module: ssd_capture

---
 rtl/ssd_pkg.sv | 32 +++
 rtl/seg7_decode.sv | 21 ++
 rtl/ssd_capture.sv | 201 ++++++++++++++++++++
 tb/tb_ssd_capture.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display capture block.
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SETTLE,
        ST_LOCKED
    } state_t;

    // Active-high {g,f,e,d,c,b,a} patterns for hex 0..F; entry 0 is the rightmost.
    localparam logic [15:0][6:0] SEG_TAB = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Digits that carry no data and must read blank.
    localparam logic [7:0] BLANK_MASK = 8'b0010_0100;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

    function automatic logic [2:0] oh2idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = i[2:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
module seg7_decode
    import ssd_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic       o_valid,
    output logic [3:0] o_nib
);

    always_comb begin
        o_valid = 1'b0;
        o_nib   = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (i_pat == SEG_TAB[i[3:0]]) begin
                o_valid = 1'b1;
                o_nib   = i[3:0];
            end
        end
    end

endmodule

// File: rtl/ssd_capture.sv
// Captures an 8-digit multiplexed seven-segment display into nibble frames.
// Optional idle timeout enabled by defining SSD_CAPTURE_TIMEOUT_EN. SETTLE_CYCLES must be >= 2.
module ssd_capture
    import ssd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [6:0] cat_in,
    input  logic [7:0] an_in,
    input  logic       ready_in,
    output logic       valid_out,
    output logic [7:0] channel_sel_out,
    output logic [7:0] lt_out,
    output logic [7:0] ut_out,
    output logic [7:0] err_out,
    output logic       overrun_out,
    output logic       timeout_out
);

    localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

    logic [6:0]      r_cat_s1, r_cat_s2, r_cat_prev;
    logic [7:0]      r_an_s1, r_an_s2, r_an_prev;
    state_t          r_state, w_state_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic            w_cap;
    logic [7:0][3:0] r_nib;
    logic [7:0]      r_err;
    logic [7:0]      r_mask;
    logic            r_valid, r_ovr;
    logic [7:0]      r_ch, r_lt, r_ut, r_err_o;
    logic            w_to_hit;

    logic [7:0] w_an_act;
    logic       w_an_same, w_same;
    logic [2:0] w_idx;
    logic [6:0] w_pat;
    logic       w_dec_vld, w_dig_ok, w_full;
    logic [3:0] w_dec_nib, w_dig_nib;

    // Two-stage synchronizer; the extra stage holds the prior sample for stability checks.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cat_s1   <= '1;
            r_cat_s2   <= '1;
            r_cat_prev <= '1;
            r_an_s1    <= '1;
            r_an_s2    <= '1;
            r_an_prev  <= '1;
        end else begin
            r_cat_s1   <= cat_in;
            r_cat_s2   <= r_cat_s1;
            r_cat_prev <= r_cat_s2;
            r_an_s1    <= an_in;
            r_an_s2    <= r_an_s1;
            r_an_prev  <= r_an_s2;
        end
    end

    assign w_an_act  = ~r_an_s2;
    assign w_an_same = (r_an_s2 == r_an_prev);
    assign w_same    = w_an_same && (r_cat_s2 == r_cat_prev);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_HUNT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_cap     = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (is_onehot(w_an_act)) begin
                    w_state_n = ST_SETTLE;
                    w_cnt_n   = '0;
                end
            end
            ST_SETTLE: begin
                if (!w_same) begin
                    w_state_n = ST_HUNT;
                    w_cnt_n   = '0;
                end else if (r_cnt == CW'(SETTLE_CYCLES - 2)) begin
                    // Entry sample plus SETTLE_CYCLES-1 matches gives SETTLE_CYCLES identical samples.
                    w_state_n = ST_LOCKED;
                    w_cnt_n   = '0;
                    w_cap     = 1'b1;
                end else begin
                    w_cnt_n = r_cnt + CW'(1);
                end
            end
            ST_LOCKED: begin
                if (!w_an_same) w_state_n = ST_HUNT;
            end
            default: begin
                w_state_n = ST_HUNT;
                w_cnt_n   = '0;
            end
        endcase
    end

    assign w_idx = oh2idx(w_an_act);
    assign w_pat = ~r_cat_s2;

    seg7_decode u_dec (
        .i_pat   (w_pat),
        .o_valid (w_dec_vld),
        .o_nib   (w_dec_nib)
    );

    assign w_dig_ok  = BLANK_MASK[w_idx] ? (w_pat == 7'h00) : w_dec_vld;
    assign w_dig_nib = (BLANK_MASK[w_idx] || !w_dec_vld) ? 4'h0 : w_dec_nib;
    assign w_full    = (r_mask == 8'hFF);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_nib  <= '0;
            r_err  <= '0;
            r_mask <= '0;
        end else begin
            if (w_cap) begin
                r_nib[w_idx] <= w_dig_nib;
                r_err[w_idx] <= !w_dig_ok;
            end
            r_mask <= ((w_full || w_to_hit) ? 8'h00 : r_mask) |
                      (w_cap ? (8'd1 << w_idx) : 8'h00);
        end
    end

    // A completed frame loads when the output slot is empty or being freed this cycle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_ch    <= '0;
            r_lt    <= '0;
            r_ut    <= '0;
            r_err_o <= '0;
        end else begin
            if (w_full && (!r_valid || ready_in)) begin
                r_valid <= 1'b1;
                r_ch    <= {r_nib[1], r_nib[0]};
                r_lt    <= {r_nib[4], r_nib[3]};
                r_ut    <= {r_nib[7], r_nib[6]};
                r_err_o <= r_err;
            end else if (r_valid && ready_in) begin
                r_valid <= 1'b0;
            end
            if (w_full && r_valid && !ready_in) r_ovr <= 1'b1;
        end
    end

`ifdef SSD_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_to;

    assign w_to_hit = !w_cap && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_to_cnt <= '0;
            r_to     <= 1'b0;
        end else if (w_cap) begin
            r_to_cnt <= '0;
            r_to     <= 1'b0;
        end else if (w_to_hit) begin
            r_to_cnt <= '0;
            r_to     <= 1'b1;
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
            r_to     <= 1'b0;
        end
    end

    assign timeout_out = r_to;
`else
    localparam bit TO_EN = 1'b0 && (TIMEOUT_CYCLES > 0);

    assign w_to_hit    = TO_EN;
    assign timeout_out = 1'b0;
`endif

    assign valid_out       = r_valid;
    assign channel_sel_out = r_ch;
    assign lt_out          = r_lt;
    assign ut_out          = r_ut;
    assign err_out         = r_err_o;
    assign overrun_out     = r_ovr;

endmodule

// File: tb/tb_ssd_capture.sv
// Scoreboard bench for ssd_capture: drives a multiplexed display model and checks frames.
module tb_ssd_capture;

    localparam int SC = 16;

    logic       clk_in   = 1'b0;
    logic       rst_in   = 1'b0;
    logic [6:0] cat_in   = 7'h7F;
    logic [7:0] an_in    = 8'hFF;
    logic       ready_in = 1'b1;
    logic       valid_out, overrun_out, timeout_out;
    logic [7:0] channel_sel_out, lt_out, ut_out, err_out;

    always #5 clk_in = ~clk_in;

    ssd_capture #(.SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(1000)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .cat_in          (cat_in),
        .an_in           (an_in),
        .ready_in        (ready_in),
        .valid_out       (valid_out),
        .channel_sel_out (channel_sel_out),
        .lt_out          (lt_out),
        .ut_out          (ut_out),
        .err_out         (err_out),
        .overrun_out     (overrun_out),
        .timeout_out     (timeout_out)
    );

    typedef struct packed {
        logic [7:0] ch;
        logic [7:0] lt;
        logic [7:0] ut;
        logic [7:0] err;
    } frame_t;

    frame_t sb_q[$];
    frame_t mon_e;
    int     total = 0;
    int     bad   = 0;
    int     n_vld = 0;
    bit     chk_drop = 1'b0;

    logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Consumer-side monitor: every handshake pops one expected frame.
    always @(negedge clk_in) begin
        if (rst_in) begin
            if (chk_drop) begin
                chk("vld_drop", {31'd0, valid_out}, 32'd0);
                chk_drop = 1'b0;
            end
            if (valid_out) n_vld++;
            if (valid_out && ready_in) begin
                if (sb_q.size() == 0) begin
                    chk("unexp_frame", 32'd1, 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("ch",  {24'd0, channel_sel_out}, {24'd0, mon_e.ch});
                    chk("lt",  {24'd0, lt_out},          {24'd0, mon_e.lt});
                    chk("ut",  {24'd0, ut_out},          {24'd0, mon_e.ut});
                    chk("err", {24'd0, err_out},         {24'd0, mon_e.err});
                end
                chk_drop = 1'b1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input int d, input logic [6:0] pat, input int n);
        an_in  = ~(8'd1 << d);
        cat_in = ~pat;
        cyc(n);
    endtask

    task automatic idle(input int n);
        an_in  = 8'hFF;
        cat_in = 7'h7F;
        cyc(n);
    endtask

    function automatic frame_t mkf(input logic [7:0][3:0] n, input logic [7:0] e);
        frame_t f;
        f.ch  = {n[1], n[0]};
        f.lt  = {n[4], n[3]};
        f.ut  = {n[7], n[6]};
        f.err = e;
        return f;
    endfunction

    // Full sweep of digits 0..7; blank digits 2 and 5 show nothing.
    task automatic send(input logic [7:0][3:0] n, input bit push);
        for (int d = 0; d < 8; d++) begin
            if (d == 7 && push) sb_q.push_back(mkf(n, 8'h00));
            drive(d, (d == 2 || d == 5) ? 7'h00 : SEG[n[d]], 100);
        end
        idle(5);
    endtask

    task automatic wait_sb();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            cyc(1);
            k++;
        end
        chk("sb_drain", sb_q.size(), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld"}, {31'd0, valid_out},   32'd0);
        chk({tag, "_ch"},  {24'd0, channel_sel_out}, 32'd0);
        chk({tag, "_lt"},  {24'd0, lt_out},      32'd0);
        chk({tag, "_ut"},  {24'd0, ut_out},      32'd0);
        chk({tag, "_err"}, {24'd0, err_out},     32'd0);
        chk({tag, "_ovr"}, {31'd0, overrun_out}, 32'd0);
        chk({tag, "_to"},  {31'd0, timeout_out}, 32'd0);
    endtask

    initial begin
        logic [7:0][3:0] rn;
        int              nv;
        bit              seen;

        cyc(3);
        chk_zero("rst");
        rst_in = 1'b1;
        cyc(3);
        chk("post_rst_vld", {31'd0, valid_out}, 32'd0);

        // Basic frames: fixed patterns then random nibbles.
        send(32'hFF01005A, 1'b1);
        wait_sb();
        send(32'h3C0E4012, 1'b1);
        wait_sb();
        for (int r = 0; r < 3; r++) begin
            rn    = $urandom;
            rn[2] = 4'h0;
            rn[5] = 4'h0;
            send(rn, 1'b1);
            wait_sb();
        end

        // Digit 3 flickers every 5 cycles, so it never settles and no frame completes.
        nv = n_vld;
        drive(0, SEG[1], 100);
        drive(1, SEG[2], 100);
        drive(2, 7'h00, 100);
        for (int t = 0; t < 12; t++) drive(3, t[0] ? SEG[8] : SEG[7], 5);
        drive(4, SEG[4], 100);
        drive(5, 7'h00, 100);
        drive(6, SEG[6], 100);
        drive(7, SEG[7], 100);
        idle(30);
        chk("settle_nocap", n_vld, nv);
        sb_q.push_back(mkf(32'h76049021, 8'h00));
        drive(3, SEG[9], 20);
        idle(30);
        wait_sb();

        // Bad patterns: digit 2 not blank, digit 4 not in the table.
        drive(0, SEG[3], 100);
        drive(1, SEG[8], 100);
        drive(2, 7'h06, 100);
        drive(3, SEG[5], 100);
        drive(4, 7'h49, 100);
        drive(5, 7'h00, 100);
        drive(6, SEG[10], 100);
        sb_q.push_back('{ch: 8'h83, lt: 8'h05, ut: 8'hBA, err: 8'h14});
        drive(7, SEG[11], 100);
        idle(5);
        wait_sb();
        chk("ovr_clear", {31'd0, overrun_out}, 32'd0);

        // Back-pressure: second frame is dropped, first one stays held.
        ready_in = 1'b0;
        send(32'h12034056, 1'b1);
        send(32'h98076054, 1'b0);
        chk("ovr_set",  {31'd0, overrun_out}, 32'd1);
        chk("ovr_vld",  {31'd0, valid_out},   32'd1);
        chk("ovr_hold", {24'd0, channel_sel_out}, 32'h56);
        chk("ovr_ut",   {24'd0, ut_out},      32'h12);
        ready_in = 1'b1;
        wait_sb();
        cyc(2);
        chk("ovr_sticky", {31'd0, overrun_out}, 32'd1);
        chk("ovr_vld_lo", {31'd0, valid_out},   32'd0);

        // Reset mid-frame discards the five captured digits.
        for (int d = 0; d < 5; d++) drive(d, (d == 2) ? 7'h00 : SEG[d + 1], 100);
        rst_in = 1'b0;
        cyc(2);
        chk_zero("mid_rst");
        rst_in = 1'b1;
        nv = n_vld;
        drive(5, 7'h00, 100);
        drive(6, SEG[2], 100);
        drive(7, SEG[3], 100);
        idle(30);
        chk("rst_partial", n_vld, nv);
        sb_q.push_back(mkf(32'h32067054, 8'h00));
        drive(0, SEG[4], 100);
        drive(1, SEG[5], 100);
        drive(2, 7'h00, 100);
        drive(3, SEG[7], 100);
        drive(4, SEG[6], 100);
        idle(30);
        wait_sb();

`ifdef SSD_CAPTURE_TIMEOUT_EN
        // Drive stops after three digits; timeout must wipe them.
        drive(0, SEG[1], 100);
        drive(1, SEG[2], 100);
        drive(2, 7'h00, 100);
        an_in  = 8'hFF;
        cat_in = 7'h7F;
        seen   = 1'b0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            cyc(1);
            if (timeout_out) seen = 1'b1;
        end
        chk("to_seen", {31'd0, seen}, 32'd1);
        cyc(1);
        chk("to_pulse", {31'd0, timeout_out}, 32'd0);
        nv = n_vld;
        for (int d = 3; d < 8; d++) drive(d, (d == 5) ? 7'h00 : SEG[d], 100);
        idle(30);
        chk("to_mask_clr", n_vld, nv);
`else
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cyc(1);
            if (timeout_out) seen = 1'b1;
        end
        chk("to_tied", {31'd0, seen}, 32'd0);
`endif

        chk("sb_final", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
